ball_centroid_tracker: RTL and testbench
========================================

// Module: ball_centroid_tracker
// PURPOSE
//  Sits downstream of the VGA controller/RAW2RGB path on the VGA pixel clock. Classifies each
//  displayed RGB pixel against colour thresholds and accumulates count plus x/y sums per frame.
//  At frame end it computes the centroid with an iterative divider and presents it to the Nios
//  PIO through a valid/ack handshake. This is the ball position source for the ping-pong game.
// PARAMETERS
//  H_ACTIVE    640  active pixels per line; pixels with x >= H_ACTIVE are ignored
//  V_ACTIVE    480  active lines per frame; lines with y >= V_ACTIVE are ignored
//  MIN_PIXELS  16   minimum matching-pixel count for the ball to be reported as found
//  SUM_W       28   accumulator/dividend width (640*480*639 < 2^28)
//  CNT_W       19   pixel-count/divisor width (640*480 < 2^19)
// PORTS
//  iCLK       in   1      VGA pixel clock (VGA_CLK)
//  iRST       in   1      synchronous, active-high reset
//  iDE        in   1      pixel valid (READ_Request); high for each active pixel
//  iVS        in   1      vertical sync, active low (VGA_VS)
//  iR/iG/iB   in   8 ea   pixel colour, valid when iDE=1
//  iR_MIN     in   8      match requires iR >= iR_MIN
//  iG_MAX     in   8      match requires iG <= iG_MAX
//  iB_MAX     in   8      match requires iB <= iB_MAX
//  iACK       in   1      one-cycle pulse from software: result consumed
//  oX         out  10     centroid x, truncated
//  oY         out  9      centroid y, truncated
//  oPIX_CNT   out  CNT_W  matching-pixel count of the reported frame
//  oFOUND     out  1      1 if oPIX_CNT >= MIN_PIXELS
//  oVALID     out  1      result pending software ack
//  oOVERRUN   out  1      sticky: a result was overwritten before it was acked
//  oFRAME_CNT out  8      frames published, wraps 255->0
// BEHAVIOUR
//  Reset: all outputs 0, accumulators 0, x=y=0, state ACCUM, skip_first=1.
//  Counters: x increments per iDE=1 cycle. On the iDE 1->0 edge, x resets to 0 and y increments,
//   saturating at V_ACTIVE. The frame-end edge (below) resets both to 0.
//  Match: iDE & x<H_ACTIVE & y<V_ACTIVE & thresholds met -> cnt+=1, sx+=x, sy+=y (same cycle).
//  Frame end: on the cycle iVS is sampled 0 after being 1 (vs_d register):
//   - If skip_first=1 (first edge after reset, partial frame): clear accumulators, clear
//     skip_first, and publish nothing.
//   - Otherwise, if state=ACCUM: latch cnt/sx/sy into divider operands and clear the
//     accumulators in the same cycle; the pixel on that cycle is discarded. Then:
//     - cnt < MIN_PIXELS: go to PUBLISH with X=Y=0 and FOUND=0, skipping division.
//     - otherwise: go to DIV_X.
//   - If state is not ACCUM (divider busy): clear the accumulators and drop the frame silently.
//  FSM: ACCUM -> DIV_X (28 cycles) -> DIV_Y (28 cycles) -> PUBLISH (1 cycle) -> ACCUM.
//   Accumulation continues in every state.
//  Divider: restoring, 1 quotient bit/cycle, SUM_W-bit dividend / CNT_W-bit divisor, truncating.
//   Quotient bits above 10 (x) or 9 (y) are always 0 and are dropped.
//  Latency: oVALID is high after the 57th rising edge following the frame-end detection edge.
//   With cnt < MIN_PIXELS it is high after the 1st.
//  PUBLISH: oX/oY/oPIX_CNT/oFOUND update, oVALID<=1, oFRAME_CNT+=1. If oVALID was already 1 and
//   iACK=0, oOVERRUN<=1.
//  iACK: clears oVALID and oOVERRUN. If iACK and PUBLISH coincide, PUBLISH wins: oVALID stays 1
//   and oOVERRUN is cleared. Data outputs hold between publishes.
//  iRST at any time: aborts any division, no publish; the next frame end is treated as partial.
// TESTING
//  16 matching px at x=100..103, y=50..53 -> oX=101, oY=51, oPIX_CNT=16, oFOUND=1.
//   oVALID is high 57 cycles after the frame-end edge.
//  15 matching px -> oFOUND=0, oX=0, oY=0, oPIX_CNT=15; oVALID one cycle after the frame edge.
//  Full 640x480 frame matching -> oPIX_CNT=307200, oX=319, oY=239; no accumulator overflow.
//  Two frames without iACK -> oOVERRUN=1, second frame data shown, oFRAME_CNT=2.
//   Then an iACK pulse -> oVALID=0, oOVERRUN=0.
//  iACK in the PUBLISH cycle -> oVALID=1, oOVERRUN=0.
//  iRST during DIV_X -> all outputs 0. The first frame end after release publishes nothing;
//   the second frame end publishes.

Source files
------------

// File: rtl/ball_centroid_tracker_if.sv
// Result bus from the ball centroid tracker to the Nios PIO.
// The tracker drives the master side; software acks on the slave side.
interface ball_centroid_tracker_if #(
    parameter int CNT_W = 19
);
    logic             iACK;
    logic [9:0]       oX;
    logic [8:0]       oY;
    logic [CNT_W-1:0] oPIX_CNT;
    logic             oFOUND;
    logic             oVALID;
    logic             oOVERRUN;
    logic [7:0]       oFRAME_CNT;

    modport master (
        input  iACK,
        output oX, oY, oPIX_CNT, oFOUND,
        output oVALID, oOVERRUN, oFRAME_CNT
    );

    modport slave (
        output iACK,
        input  oX, oY, oPIX_CNT, oFOUND,
        input  oVALID, oOVERRUN, oFRAME_CNT
    );
endinterface

// File: rtl/ball_centroid_tracker.sv
// Colour-threshold ball tracker: per-frame pixel count and x/y sums,
// centroid via a restoring divider, published over a valid/ack bus.
module ball_centroid_tracker #(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int MIN_PIXELS = 16,
    parameter int SUM_W      = 28,
    parameter int CNT_W      = 19
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic       iDE,
    input  logic       iVS,
    input  logic [7:0] iR,
    input  logic [7:0] iG,
    input  logic [7:0] iB,
    input  logic [7:0] iR_MIN,
    input  logic [7:0] iG_MAX,
    input  logic [7:0] iB_MAX,
    ball_centroid_tracker_if.master res
);
    typedef enum logic [1:0] {ACCUM, DIV_X, DIV_Y, PUBLISH} state_t;

    localparam logic [10:0]      H_LIM = 11'(H_ACTIVE);
    localparam logic [9:0]       V_LIM = 10'(V_ACTIVE);
    localparam logic [CNT_W-1:0] M_LIM = CNT_W'(MIN_PIXELS);
    localparam logic [4:0]       LAST  = 5'(SUM_W - 1);

    state_t           state_q, state_d;
    logic [10:0]      x_q, x_d;
    logic [9:0]       y_q, y_d;
    logic             de_q, vs_q;
    logic             skip_q, skip_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SUM_W-1:0] sx_q, sx_d, sy_q, sy_d;
    logic [SUM_W-1:0] dvd_q, dvd_d, syop_q, syop_d;
    logic [CNT_W-1:0] dvs_q, dvs_d;
    logic [CNT_W:0]   rem_q, rem_d;
    logic [4:0]       bit_q, bit_d;
    logic [9:0]       qx_q, qx_d;
    logic [8:0]       qy_q, qy_d;
    logic [9:0]       ox_q, ox_d;
    logic [8:0]       oy_q, oy_d;
    logic [CNT_W-1:0] pix_q, pix_d;
    logic             fnd_q, fnd_d;
    logic             vld_q, vld_d;
    logic             ovr_q, ovr_d;
    logic [7:0]       fcnt_q, fcnt_d;

    logic             fe, match, ge;
    logic [CNT_W:0]   rem_sh, rem_nx;
    logic [SUM_W-1:0] quo_nx;

    always_comb begin
        fe     = vs_q & ~iVS;
        match  = iDE && (x_q < H_LIM) && (y_q < V_LIM) &&
                 (iR >= iR_MIN) && (iG <= iG_MAX) && (iB <= iB_MAX);
        // One restoring step: quotient bits shift in behind the dividend
        rem_sh = {rem_q[CNT_W-1:0], dvd_q[SUM_W-1]};
        ge     = rem_sh >= {1'b0, dvs_q};
        rem_nx = ge ? rem_sh - {1'b0, dvs_q} : rem_sh;
        quo_nx = {dvd_q[SUM_W-2:0], ge};

        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        skip_d  = skip_q;
        cnt_d   = cnt_q;
        sx_d    = sx_q;
        sy_d    = sy_q;
        dvd_d   = dvd_q;
        syop_d  = syop_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        bit_d   = bit_q;
        qx_d    = qx_q;
        qy_d    = qy_q;
        ox_d    = ox_q;
        oy_d    = oy_q;
        pix_d   = pix_q;
        fnd_d   = fnd_q;
        vld_d   = vld_q;
        ovr_d   = ovr_q;
        fcnt_d  = fcnt_q;

        if (fe) begin
            x_d = '0;
            y_d = '0;
        end else if (de_q && !iDE) begin
            x_d = '0;
            if (y_q < V_LIM) y_d = y_q + 10'd1;
        end else if (iDE && (x_q != '1)) begin
            x_d = x_q + 11'd1;
        end

        if (fe) begin
            cnt_d  = '0;
            sx_d   = '0;
            sy_d   = '0;
            skip_d = 1'b0;
        end else if (match) begin
            cnt_d = cnt_q + CNT_W'(1);
            sx_d  = sx_q + SUM_W'(x_q);
            sy_d  = sy_q + SUM_W'(y_q);
        end

        if (res.iACK) begin
            vld_d = 1'b0;
            ovr_d = 1'b0;
        end

        unique case (state_q)
            ACCUM: begin
                if (fe && !skip_q) begin
                    dvd_d  = sx_q;
                    syop_d = sy_q;
                    dvs_d  = cnt_q;
                    rem_d  = '0;
                    bit_d  = '0;
                    if (cnt_q < M_LIM) begin
                        qx_d    = '0;
                        qy_d    = '0;
                        state_d = PUBLISH;
                    end else begin
                        state_d = DIV_X;
                    end
                end
            end
            DIV_X: begin
                dvd_d = quo_nx;
                rem_d = rem_nx;
                bit_d = bit_q + 5'd1;
                if (bit_q == LAST) begin
                    qx_d    = quo_nx[9:0];
                    dvd_d   = syop_q;
                    rem_d   = '0;
                    bit_d   = '0;
                    state_d = DIV_Y;
                end
            end
            DIV_Y: begin
                dvd_d = quo_nx;
                rem_d = rem_nx;
                bit_d = bit_q + 5'd1;
                if (bit_q == LAST) begin
                    qy_d    = quo_nx[8:0];
                    state_d = PUBLISH;
                end
            end
            PUBLISH: begin
                ox_d    = qx_q;
                oy_d    = qy_q;
                pix_d   = dvs_q;
                fnd_d   = dvs_q >= M_LIM;
                vld_d   = 1'b1;
                ovr_d   = res.iACK ? 1'b0 : (ovr_q | vld_q);
                fcnt_d  = fcnt_q + 8'd1;
                state_d = ACCUM;
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q <= ACCUM;
            x_q     <= '0;
            y_q     <= '0;
            de_q    <= 1'b0;
            vs_q    <= 1'b0;
            skip_q  <= 1'b1;
            cnt_q   <= '0;
            sx_q    <= '0;
            sy_q    <= '0;
            dvd_q   <= '0;
            syop_q  <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            bit_q   <= '0;
            qx_q    <= '0;
            qy_q    <= '0;
            ox_q    <= '0;
            oy_q    <= '0;
            pix_q   <= '0;
            fnd_q   <= 1'b0;
            vld_q   <= 1'b0;
            ovr_q   <= 1'b0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            de_q    <= iDE;
            vs_q    <= iVS;
            skip_q  <= skip_d;
            cnt_q   <= cnt_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            dvd_q   <= dvd_d;
            syop_q  <= syop_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            bit_q   <= bit_d;
            qx_q    <= qx_d;
            qy_q    <= qy_d;
            ox_q    <= ox_d;
            oy_q    <= oy_d;
            pix_q   <= pix_d;
            fnd_q   <= fnd_d;
            vld_q   <= vld_d;
            ovr_q   <= ovr_d;
            fcnt_q  <= fcnt_d;
        end
    end

    assign res.oX         = ox_q;
    assign res.oY         = oy_q;
    assign res.oPIX_CNT   = pix_q;
    assign res.oFOUND     = fnd_q;
    assign res.oVALID     = vld_q;
    assign res.oOVERRUN   = ovr_q;
    assign res.oFRAME_CNT = fcnt_q;
endmodule

// File: tb/tb_ball_centroid_tracker.sv
// Bench for ball_centroid_tracker: drives synthetic frames and checks
// each published result against a per-frame arithmetic model.
module tb_ball_centroid_tracker;
    localparam int H  = 128;
    localparam int V  = 64;
    localparam int MP = 16;
    localparam int CW = 19;

    logic       clk = 1'b0;
    logic       rst, de, vs;
    logic [7:0] r, g, b;
    logic [7:0] r_min, g_max, b_max;

    ball_centroid_tracker_if #(.CNT_W(CW)) bus ();

    ball_centroid_tracker #(
        .H_ACTIVE(H), .V_ACTIVE(V), .MIN_PIXELS(MP),
        .SUM_W(28), .CNT_W(CW)
    ) dut (
        .iCLK(clk), .iRST(rst), .iDE(de), .iVS(vs),
        .iR(r), .iG(g), .iB(b),
        .iR_MIN(r_min), .iG_MAX(g_max), .iB_MAX(b_max),
        .res(bus.master)
    );

    always #5 clk = ~clk;

    int     tests = 0;
    int     fails = 0;
    int     m_cnt, e_x, e_y, e_lat, e_fcnt;
    longint m_sx, m_sy;
    bit     e_fnd;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive h lines of w pixels; pixels inside the box are matching
    // (or random near-threshold colours when rnd), others never match.
    task automatic send_lines(input int w, input int h,
                              input int bx0, input int bx1,
                              input int by0, input int by1,
                              input bit rnd);
        m_cnt = 0;
        m_sx  = 0;
        m_sy  = 0;
        for (int yy = 0; yy < h; yy++) begin
            for (int xx = 0; xx < w; xx++) begin
                de = 1'b1;
                if (xx >= bx0 && xx <= bx1 && yy >= by0 && yy <= by1) begin
                    if (rnd) begin
                        r = 8'($urandom_range(255, 96));
                        g = 8'($urandom_range(100, 0));
                        b = 8'($urandom_range(100, 0));
                    end else begin
                        r = 8'd200; g = 8'd20; b = 8'd20;
                    end
                end else begin
                    r = 8'd10; g = 8'd200; b = 8'd200;
                end
                if (xx < H && yy < V && r >= r_min &&
                    g <= g_max && b <= b_max) begin
                    m_cnt++;
                    m_sx += xx;
                    m_sy += yy;
                end
                tick();
            end
            de = 1'b0;
            repeat (3) tick();
        end
    endtask

    task automatic predict();
        e_fnd = (m_cnt >= MP);
        e_x   = e_fnd ? int'(m_sx / m_cnt) : 0;
        e_y   = e_fnd ? int'(m_sy / m_cnt) : 0;
        e_lat = e_fnd ? 57 : 1;
        e_fcnt++;
    endtask

    // Returns with time 1 unit after the frame-end detection edge
    task automatic frame_end();
        vs = 1'b0;
        tick();
        vs = 1'b1;
    endtask

    task automatic wait_pub(output int n);
        logic [7:0] old;
        old = bus.oFRAME_CNT;
        n = -1;
        for (int i = 1; i <= 200; i++) begin
            tick();
            if (bus.oFRAME_CNT !== old) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic ack();
        bus.iACK = 1'b1;
        tick();
        bus.iACK = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        e_fcnt = 0;
        tests++;
        if ({bus.oX, bus.oY, bus.oPIX_CNT, bus.oFOUND, bus.oVALID,
             bus.oOVERRUN, bus.oFRAME_CNT} !== '0) begin
            fails++;
            $display("FAIL reset: x=%0d y=%0d cnt=%0d v=%b o=%b f=%0d, want all 0",
                     bus.oX, bus.oY, bus.oPIX_CNT, bus.oVALID,
                     bus.oOVERRUN, bus.oFRAME_CNT);
        end
    endtask

    task automatic test_partial_first();
        send_lines(20, 10, 2, 5, 2, 5, 1'b0);
        frame_end();
        repeat (80) tick();
        tests++;
        if (bus.oVALID !== 1'b0 || bus.oFRAME_CNT !== 8'd0) begin
            fails++;
            $display("FAIL partial_first: valid=%b fcnt=%0d, want 0 0",
                     bus.oVALID, bus.oFRAME_CNT);
        end
    endtask

    task automatic test_centroid16();
        int n;
        send_lines(104, 54, 100, 103, 50, 53, 1'b0);
        frame_end();
        wait_pub(n);
        predict();
        tests++;
        if (n != 57) begin
            fails++;
            $display("FAIL c16_latency: got %0d, want 57", n);
        end
        tests++;
        if ({bus.oX, bus.oY, bus.oPIX_CNT, bus.oFOUND, bus.oVALID} !==
            {10'd101, 9'd51, 19'd16, 1'b1, 1'b1}) begin
            fails++;
            $display("FAIL c16_data: x=%0d y=%0d cnt=%0d fnd=%b v=%b, want 101 51 16 1 1",
                     bus.oX, bus.oY, bus.oPIX_CNT, bus.oFOUND, bus.oVALID);
        end
        ack();
        tests++;
        if (bus.oVALID !== 1'b0) begin
            fails++;
            $display("FAIL c16_ack: valid=%b, want 0", bus.oVALID);
        end
    endtask

    task automatic test_below_min();
        int n;
        send_lines(106, 54, 100, 104, 50, 52, 1'b0);
        frame_end();
        wait_pub(n);
        predict();
        tests++;
        if (n != 1) begin
            fails++;
            $display("FAIL below_latency: got %0d, want 1", n);
        end
        tests++;
        if ({bus.oX, bus.oY, bus.oPIX_CNT, bus.oFOUND, bus.oFRAME_CNT} !==
            {10'd0, 9'd0, 19'd15, 1'b0, 8'(e_fcnt)}) begin
            fails++;
            $display("FAIL below_data: x=%0d y=%0d cnt=%0d fnd=%b f=%0d, want 0 0 15 0 %0d",
                     bus.oX, bus.oY, bus.oPIX_CNT, bus.oFOUND,
                     bus.oFRAME_CNT, e_fcnt);
        end
        ack();
    endtask

    task automatic test_full_frame();
        int n;
        send_lines(H + 2, V + 2, 0, H + 1, 0, V + 1, 1'b0);
        frame_end();
        wait_pub(n);
        predict();
        tests++;
        if ({bus.oX, bus.oY, bus.oPIX_CNT, bus.oFOUND} !==
            {10'(H / 2 - 1), 9'(V / 2 - 1), 19'(H * V), 1'b1} || n != 57) begin
            fails++;
            $display("FAIL full_frame: x=%0d y=%0d cnt=%0d lat=%0d, want %0d %0d %0d 57",
                     bus.oX, bus.oY, bus.oPIX_CNT, n, H / 2 - 1, V / 2 - 1, H * V);
        end
        ack();
    endtask

    task automatic test_random();
        int n, w, h, x0, x1, y0, y1;
        for (int k = 0; k < 4; k++) begin
            w  = $urandom_range(H + 3, 16);
            h  = $urandom_range(V + 2, 8);
            x0 = $urandom_range(w - 1, 0);
            x1 = $urandom_range(w - 1, x0);
            y0 = $urandom_range(h - 1, 0);
            y1 = $urandom_range(h - 1, y0);
            send_lines(w, h, x0, x1, y0, y1, 1'b1);
            frame_end();
            wait_pub(n);
            predict();
            tests++;
            if ({bus.oX, bus.oY, bus.oPIX_CNT, bus.oFOUND, bus.oFRAME_CNT} !==
                {10'(e_x), 9'(e_y), 19'(m_cnt), e_fnd, 8'(e_fcnt)} ||
                n != e_lat) begin
                fails++;
                $display("FAIL random%0d: x=%0d y=%0d cnt=%0d lat=%0d, want %0d %0d %0d %0d",
                         k, bus.oX, bus.oY, bus.oPIX_CNT, n,
                         e_x, e_y, m_cnt, e_lat);
            end
            ack();
        end
    endtask

    task automatic two_frames_no_ack();
        int n;
        send_lines(8, 8, 2, 5, 2, 5, 1'b0);
        frame_end();
        wait_pub(n);
        predict();
        send_lines(16, 8, 10, 13, 2, 5, 1'b0);
        frame_end();
        wait_pub(n);
        predict();
    endtask

    task automatic test_overrun();
        two_frames_no_ack();
        tests++;
        if ({bus.oX, bus.oY, bus.oPIX_CNT, bus.oVALID, bus.oOVERRUN,
             bus.oFRAME_CNT} !== {10'd11, 9'd3, 19'd16, 1'b1, 1'b1,
             8'(e_fcnt)}) begin
            fails++;
            $display("FAIL overrun: x=%0d y=%0d v=%b o=%b f=%0d, want 11 3 1 1 %0d",
                     bus.oX, bus.oY, bus.oVALID, bus.oOVERRUN,
                     bus.oFRAME_CNT, e_fcnt);
        end
        ack();
        tests++;
        if (bus.oVALID !== 1'b0 || bus.oOVERRUN !== 1'b0) begin
            fails++;
            $display("FAIL overrun_ack: v=%b o=%b, want 0 0",
                     bus.oVALID, bus.oOVERRUN);
        end
    endtask

    task automatic test_ack_in_publish();
        two_frames_no_ack();
        tests++;
        if (bus.oOVERRUN !== 1'b1) begin
            fails++;
            $display("FAIL pub_ack_setup: o=%b, want 1", bus.oOVERRUN);
        end
        send_lines(8, 8, 1, 4, 3, 6, 1'b0);
        frame_end();
        repeat (56) tick();
        bus.iACK = 1'b1;
        tick();
        bus.iACK = 1'b0;
        predict();
        tests++;
        if ({bus.oVALID, bus.oOVERRUN, bus.oX, bus.oY, bus.oFRAME_CNT} !==
            {1'b1, 1'b0, 10'd2, 9'd4, 8'(e_fcnt)}) begin
            fails++;
            $display("FAIL pub_ack: v=%b o=%b x=%0d y=%0d f=%0d, want 1 0 2 4 %0d",
                     bus.oVALID, bus.oOVERRUN, bus.oX, bus.oY,
                     bus.oFRAME_CNT, e_fcnt);
        end
        ack();
    endtask

    task automatic test_reset_in_div();
        int n;
        send_lines(8, 8, 2, 5, 2, 5, 1'b0);
        frame_end();
        repeat (10) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        e_fcnt = 0;
        tests++;
        if ({bus.oX, bus.oY, bus.oPIX_CNT, bus.oFOUND, bus.oVALID,
             bus.oOVERRUN, bus.oFRAME_CNT} !== '0) begin
            fails++;
            $display("FAIL rst_div: x=%0d v=%b f=%0d, want all 0",
                     bus.oX, bus.oVALID, bus.oFRAME_CNT);
        end
        repeat (70) tick();
        tests++;
        if (bus.oVALID !== 1'b0) begin
            fails++;
            $display("FAIL rst_div_abort: v=%b, want 0", bus.oVALID);
        end
        send_lines(8, 8, 2, 5, 2, 5, 1'b0);
        frame_end();
        repeat (80) tick();
        tests++;
        if (bus.oVALID !== 1'b0 || bus.oFRAME_CNT !== 8'd0) begin
            fails++;
            $display("FAIL rst_div_partial: v=%b f=%0d, want 0 0",
                     bus.oVALID, bus.oFRAME_CNT);
        end
        send_lines(8, 8, 3, 6, 1, 4, 1'b0);
        frame_end();
        wait_pub(n);
        predict();
        tests++;
        if ({bus.oVALID, bus.oX, bus.oY, bus.oFRAME_CNT} !==
            {1'b1, 10'd4, 9'd2, 8'd1} || n != 57) begin
            fails++;
            $display("FAIL rst_div_second: v=%b x=%0d y=%0d f=%0d lat=%0d, want 1 4 2 1 57",
                     bus.oVALID, bus.oX, bus.oY, bus.oFRAME_CNT, n);
        end
    endtask

    initial begin
        rst      = 1'b1;
        de       = 1'b0;
        vs       = 1'b1;
        r        = '0;
        g        = '0;
        b        = '0;
        r_min    = 8'd128;
        g_max    = 8'd64;
        b_max    = 8'd64;
        bus.iACK = 1'b0;
        e_fcnt   = 0;
        test_reset();
        test_partial_first();
        test_centroid16();
        test_below_min();
        test_full_frame();
        test_random();
        test_overrun();
        test_ack_in_publish();
        test_reset_in_div();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
